solver_monitor: RTL

Synthesizable run-control and result-reporting block for the puzzle-solver top level. It starts a run across `NUM_CHANNELS` solver instances and records each channel's first completion or error, with a timeout watchdog for channels that never finish. Once the run ends it serializes a per-channel result record as bytes over a valid/ready stream for a UART or debug link. It replaces simulation-only answer printing with hardware reporting and scales to multiple solvers or puzzle parts.

---
 rtl/solver_monitor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/solver_monitor.sv
// Run control for NUM_CHANNELS solvers: latches first done/error per channel, watchdog-times-out the rest, then streams results.
// REPORT starts the cycle after the run completes; one byte per accepted cycle; TxData/TxValid hold while TxReady is low.
module solver_monitor #(
    parameter int NUM_CHANNELS   = 2,
    parameter int ANSWER_WIDTH   = 64,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                                 Clk,
    input  logic                                 ResetN,
    input  logic                                 Start,
    input  logic [NUM_CHANNELS-1:0]              ChDone,
    input  logic [NUM_CHANNELS-1:0]              ChError,
    input  logic [NUM_CHANNELS*ANSWER_WIDTH-1:0] ChAnswer,
    output logic [7:0]                           TxData,
    output logic                                 TxValid,
    input  logic                                 TxReady,
    output logic                                 Busy,
    output logic                                 Done,
    output logic                                 Error,
    output logic                                 Timeout
);
    localparam int ANS_BYTES = ANSWER_WIDTH / 8;
    localparam int WD_W      = $clog2(TIMEOUT_CYCLES);
    localparam int CH_W      = 7;
    localparam int BI_W      = $clog2(ANS_BYTES + 1);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CHANNELS - 1);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(ANS_BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_REPORT, ST_FINISH} state_t;

    state_t                             state_q, state_d;
    logic [2*NUM_CHANNELS-1:0]          status_q, status_d;
    logic [NUM_CHANNELS*ANSWER_WIDTH-1:0] answer_q, answer_d;
    logic [WD_W-1:0]                    wdog_q, wdog_d;
    logic [CH_W-1:0]                    ch_q, ch_d;
    logic [BI_W-1:0]                    bi_q, bi_d;
    logic                               tx_valid_q, tx_valid_d;
    logic [7:0]                         tx_data_q, tx_data_d;
    logic                               any_pending;
    logic                               err_any, to_any;
    int                                 ci;

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        answer_d    = answer_q;
        wdog_d      = wdog_q;
        ch_d        = ch_q;
        bi_d        = bi_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = 8'h00;
        any_pending = 1'b0;
        ci          = 0;

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (Start) begin
                    state_d  = ST_RUN;
                    status_d = '0;
                    answer_d = '0;
                    wdog_d   = '0;
                end
            end
            ST_RUN: begin
                wdog_d = wdog_q + WD_W'(1);
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (status_q[2*i +: 2] == 2'b00) begin
                        if (ChError[i]) begin
                            status_d[2*i +: 2] = 2'b10;
                        end else if (ChDone[i]) begin
                            status_d[2*i +: 2] = 2'b01;
                            answer_d[i*ANSWER_WIDTH +: ANSWER_WIDTH] = ChAnswer[i*ANSWER_WIDTH +: ANSWER_WIDTH];
                        end
                    end
                end
                // Timeout is applied after this edge's latching so late arrivals still win.
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (status_d[2*i +: 2] == 2'b00) begin
                        if (wdog_q == WD_LAST) status_d[2*i +: 2] = 2'b11;
                        else                   any_pending = 1'b1;
                    end
                end
                if (!any_pending) begin
                    state_d    = ST_REPORT;
                    ch_d       = '0;
                    bi_d       = '0;
                    tx_valid_d = 1'b1;
                end
            end
            ST_REPORT: begin
                if (TxReady) begin
                    if (bi_q == BI_LAST) begin
                        if (ch_q == CH_LAST) begin
                            state_d    = ST_FINISH;
                            tx_valid_d = 1'b0;
                        end else begin
                            ch_d = ch_q + CH_W'(1);
                            bi_d = '0;
                        end
                    end else begin
                        bi_d = bi_q + BI_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Next byte is preloaded from next-state indices so the stream never gaps.
        if (state_d == ST_REPORT) begin
            ci = int'(ch_d);
            if (bi_d == '0) tx_data_d = {status_d[2*ci +: 2], ch_d[5:0]};
            else            tx_data_d = answer_d[ci*ANSWER_WIDTH + (ANS_BYTES - int'(bi_d))*8 +: 8];
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= ST_IDLE;
            status_q   <= '0;
            answer_q   <= '0;
            wdog_q     <= '0;
            ch_q       <= '0;
            bi_q       <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            answer_q   <= answer_d;
            wdog_q     <= wdog_d;
            ch_q       <= ch_d;
            bi_q       <= bi_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        err_any = 1'b0;
        to_any  = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            err_any = err_any | status_q[2*i+1];
            to_any  = to_any  | (&status_q[2*i +: 2]);
        end
    end

    assign TxData  = tx_data_q;
    assign TxValid = tx_valid_q;
    assign Busy    = (state_q == ST_RUN) || (state_q == ST_REPORT);
    assign Done    = (state_q == ST_FINISH);
    assign Error   = Done && err_any;
    assign Timeout = Done && to_any;

endmodule
